// File: rtl/int_to_fp_seq.sv
// int_to_fp_seq
//   Sequential converter from a 32-bit sign-magnitude integer to bfloat16.
//   A request is normalised one bit per cycle (leading-zero shift), then
//   rounded and packed in a single cycle, and held until the consumer
//   takes it. Only one request is in flight at a time.
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       synchronous active-low reset
//   in_valid_i   int_in holds a request
//   in_ready_o   block is idle and can accept a request
//   int_in[31:0] sign-magnitude integer: [31] sign, [30:0] magnitude
//   out_valid_o  fp_out / flag hold a result
//   out_ready_i  consumer takes the result
//   fp_out[15:0] bfloat16 result: [15] sign, [14:7] exponent, [6:0] fraction
//   flag[2:0]    [2] inexact, [1] zero result, [0] always 0
//
// Configuration
//   INT_TO_FP_RNE_EN  defined: round-to-nearest-even; undefined: truncate.

module int_to_fp_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] int_in,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] fp_out,
  output logic [2:0]  flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic        sign_reg;
  logic [30:0] mag_reg;
  logic [4:0]  cnt_reg;
  logic [15:0] fp_reg;
  logic [2:0]  flag_reg;

  logic        accept;

  // Rounding datapath, evaluated from the normalised magnitude.
  logic [6:0]  frac;
  logic        guard;
  logic        sticky;
  logic        round_inc;
  logic [7:0]  frac_sum;
  logic [7:0]  exp_base;
  logic [7:0]  exp_out;
  logic        mag_zero;

  assign accept = (state_reg == IDLE) && in_valid_i;

  assign frac     = mag_reg[29:23];
  assign guard    = mag_reg[22];
  assign sticky   = |mag_reg[21:0];
  assign mag_zero = (mag_reg == 31'd0);

`ifdef INT_TO_FP_RNE_EN
  // Nearest-even: round up above half, or at exactly half when LSB is odd.
  assign round_inc = guard & (sticky | frac[0]);
`else
  assign round_inc = 1'b0;
`endif

  // frac_sum[7] is the carry out of the fraction; its low bits are then
  // all zero, so they can be used directly as the rounded fraction.
  assign frac_sum = {1'b0, frac} + {7'd0, round_inc};
  // The leading one sits at bit 30 after cnt_reg shifts: value 2^(30-cnt),
  // biased exponent 127 + 30 - cnt.
  assign exp_base = 8'd157 - {3'd0, cnt_reg};
  assign exp_out  = frac_sum[7] ? (exp_base + 8'd1) : exp_base;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid_i) begin
          state_next = (int_in[30:0] != 31'd0) ? NORM : ROUND;
        end
      end
      NORM: begin
        if (mag_reg[30]) begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        state_next = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_o  = (state_reg == IDLE);
    out_valid_o = (state_reg == DONE);
    fp_out      = fp_reg;
    flag        = flag_reg;
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sign_reg <= 1'b0;
      mag_reg  <= 31'd0;
      cnt_reg  <= 5'd0;
      fp_reg   <= 16'h0000;
      flag_reg <= 3'b000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            sign_reg <= int_in[31];
            mag_reg  <= int_in[30:0];
            cnt_reg  <= 5'd0;
          end
        end
        NORM: begin
          if (!mag_reg[30]) begin
            mag_reg <= {mag_reg[29:0], 1'b0};
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        ROUND: begin
          if (mag_zero) begin
            fp_reg   <= {sign_reg, 15'd0};
            flag_reg <= 3'b010;
          end else begin
            fp_reg   <= {sign_reg, exp_out, frac_sum[6:0]};
            flag_reg <= {guard | sticky, 2'b00};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/int_to_fp_seq.md
INT_TO_FP_SEQ -- requirements
Module: int_to_fp_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  synchronous active-low reset, sampled on the rising edge of clk_i.
REQ-004 in_valid_i  input  1  int_in holds a request.
REQ-005 in_ready_o  output  1  block can accept a request.
REQ-006 int_in  input  32  sign-magnitude integer: [31] sign, [30:0] unsigned magnitude.
REQ-007 out_valid_o  output  1  fp_out and flag hold a result.
REQ-008 out_ready_i  input  1  consumer takes the result.
REQ-009 fp_out  output  16  bfloat16: [15] sign, [14:7] biased exponent (bias 127), [6:0] fraction.
REQ-010 flag  output  3  [2] inexact, [1] zero result, [0] reserved and always 0.

Function
REQ-011 FSM states SHALL be IDLE, NORM, ROUND and DONE.
REQ-012 in_ready_o SHALL be 1 only in IDLE; a request is accepted on an edge where in_valid_i and in_ready_o are both 1.
REQ-013 On acceptance, the block SHALL register the sign and magnitude and clear the shift counter (5 bits).
- Nonzero magnitude: go to NORM.
- Zero magnitude: go to ROUND.
REQ-014 In NORM, each cycle:
- mag[30]=0: shift mag left by 1 and increment the counter.
- mag[30]=1: go to ROUND.
REQ-015 The NORM dwell SHALL be LZ+1 cycles, where LZ = leading zeros of the 31-bit magnitude (0..30).
REQ-016 ROUND SHALL compute the result and go to DONE in 1 cycle.
- Exponent = 157 - count.
- Fraction = mag[29:23].
- Guard = mag[22]; sticky = OR of mag[21:0].
REQ-017 Rounding carry out of the fraction SHALL increment the exponent and zero the fraction; 0x7FFFFFFF SHALL give exponent 158.
REQ-018 flag[2] SHALL be set when guard or sticky is 1, independent of the rounding mode.
REQ-019 Zero magnitude SHALL give fp_out = {sign, 15'b0} and flag = 3'b010.
REQ-020 Overflow and NaN SHALL NOT occur; no such flags exist.
REQ-021 out_valid_o SHALL be 1 only in DONE, with fp_out and flag held stable.
REQ-022 DONE SHALL go to IDLE on an edge with out_ready_i = 1; no new request is accepted on that same edge.
REQ-023 Latency, counted in edges from the accepting edge to out_valid_o rising, SHALL be LZ+2 for nonzero input and 1 for zero input.
REQ-024 Throughput SHALL be one request in flight; in_valid_i outside IDLE SHALL be ignored.
REQ-025 fp_out and flag SHALL hold their last value outside DONE.

Reset
REQ-026 rst_ni = 0 at an edge SHALL force IDLE, in_ready_o = 1 and out_valid_o = 0.
REQ-027 The same reset SHALL clear fp_out = 16'h0000, flag = 3'b000 and all internal registers to 0.
REQ-028 Reset in NORM, ROUND or DONE SHALL discard the in-flight request with no output handshake.
REQ-029 Reset SHALL take priority over acceptance and output handshakes on the same edge.

Configuration
REQ-030 The macro INT_TO_FP_RNE_EN SHALL select the rounding mode.
- Defined: round-to-nearest-even; increment when guard = 1 and (sticky = 1 or fraction LSB = 1).
- Undefined: truncate; never increment.

Verification
REQ-031 int_in = 0x00000001 -> fp_out = 0x3F80, flag = 000, out_valid_o rises 32 edges after acceptance.
REQ-032 int_in = 0x80000003 -> fp_out = 0xC040, flag = 000, latency 31.
REQ-033 int_in = 0x7FFFFFFF -> fp_out = 0x4F00 with INT_TO_FP_RNE_EN and 0x4EFF without; flag = 100 in both builds; latency 2.
REQ-034 int_in = 0x00000101 -> fp_out = 0x4380, flag = 100 (tie to even); int_in = 0x00000181 -> 0x43C0, flag = 100.
REQ-035 int_in = 0x80000000 -> fp_out = 0x8000, flag = 010, latency 1; int_in = 0 -> 0x0000.
REQ-036 Backpressure and reset:
- Hold out_ready_i = 0 for 10 cycles in DONE: output stays stable and in_ready_o = 0.
- Assert rst_ni = 0 mid-NORM: IDLE next edge, no out_valid_o.
